// File: rtl/sne_pkg.sv
// Shared types and constants for the event/data distributor.
package sne_pkg;

  // Runtime distribution modes; the reserved encoding decodes to DIST_SEQ.
  typedef enum logic [1:0] {
    DIST_SEQ    = 2'd0,
    DIST_BCAST  = 2'd1,
    DIST_TARGET = 2'd2
  } dist_mode_e;

  localparam int unsigned DIST_THRESHOLD = 128;

endpackage

// File: rtl/evt_next_enabled.sv
// Find the lowest set mask bit strictly above ptr, wrapping to the lowest set bit.
// With an empty mask the pointer is returned unchanged.
module evt_next_enabled #(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 3
) (
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic [PW-1:0] next_o
);

  // Wrap candidate first, then override with the nearest bit above ptr.
  always_comb begin
    next_o = ptr_i;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_i[i]) next_o = PW'(i);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(ptr_i))) next_o = PW'(i);
    end
  end

endmodule

// File: rtl/evt_data_distributor.sv
// Fans the crossbar weight stream out to SLICE_NUMBER slice streams in
// sequential-burst, broadcast or header-targeted mode, through a one-entry
// output register with a per-slice pending mask.
module evt_data_distributor
  import sne_pkg::*;
#(
  parameter int unsigned SLICE_NUMBER = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned THRESHOLD    = DIST_THRESHOLD,
  parameter int unsigned CNT_WIDTH    = $clog2(THRESHOLD) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    module_enable_i,
  input  logic [SLICE_NUMBER-1:0] enable_i,
  input  logic [1:0]              mode_i,
  input  logic [CNT_WIDTH-1:0]    threshold_i,
  input  logic                    evt_in_valid_i,
  output logic                    evt_in_ready_o,
  input  logic [DATA_WIDTH-1:0]   evt_in_data_i,
  output logic [SLICE_NUMBER-1:0] evt_out_valid_o,
  input  logic [SLICE_NUMBER-1:0] evt_out_ready_i,
  output logic [DATA_WIDTH-1:0]   evt_out_data_o,
  output logic                    busy_o,
  output logic                    burst_done_o
);

  localparam int unsigned PTR_W = $clog2(SLICE_NUMBER);

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SLICE_NUMBER-1:0] pend_q, pend_d;
  logic [SLICE_NUMBER-1:0] en_q, en_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  dist_mode_e              mode_q, mode_d;
  logic                    done_q, done_d;
  logic                    run_q;

  dist_mode_e              mode_in, eff_mode;
  logic [SLICE_NUMBER-1:0] eff_en;
  logic [PTR_W-1:0]        jump_ptr, start_ptr, adv_ptr, tgt;
  logic [CNT_WIDTH-1:0]    thr_m1;
  logic                    burst_start, slot_free, accept;

  // Reserved mode encoding falls back to sequential bursts.
  always_comb begin
    case (mode_i)
      2'd1:    mode_in = DIST_BCAST;
      2'd2:    mode_in = DIST_TARGET;
      default: mode_in = DIST_SEQ;
    endcase
  end

  // Mode and enable mask are only sampled on the first beat of a burst.
  assign burst_start = (cnt_q == '0);
  assign eff_mode    = burst_start ? mode_in : mode_q;
  assign eff_en      = burst_start ? enable_i : en_q;
  assign start_ptr   = (burst_start && !eff_en[ptr_q]) ? jump_ptr : ptr_q;
  assign thr_m1      = (threshold_i == '0) ? '0 : threshold_i - CNT_WIDTH'(1);
  assign tgt         = evt_in_data_i[PTR_W-1:0];

  evt_next_enabled #(.N(SLICE_NUMBER), .PW(PTR_W)) u_jump (
    .ptr_i  (ptr_q),
    .mask_i (eff_en),
    .next_o (jump_ptr)
  );

  evt_next_enabled #(.N(SLICE_NUMBER), .PW(PTR_W)) u_adv (
    .ptr_i  (start_ptr),
    .mask_i (eff_en),
    .next_o (adv_ptr)
  );

  // The register can take a new beat when every pending bit is gone by this edge.
  assign slot_free      = ((pend_q & ~evt_out_ready_i) == '0);
  assign evt_in_ready_o = run_q & module_enable_i & (|enable_i) & slot_free;
  assign accept         = evt_in_valid_i & evt_in_ready_o;

  // Next-state: drain pending bits, load accepted beats, step the burst.
  always_comb begin
    pend_d = pend_q & ~evt_out_ready_i;
    data_d = data_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    en_d   = en_q;
    done_d = 1'b0;
    if (accept) begin
      data_d = evt_in_data_i;
      mode_d = eff_mode;
      en_d   = eff_en;
      case (eff_mode)
        DIST_BCAST:  pend_d = eff_en;
        DIST_TARGET: pend_d = eff_en[tgt] ? (SLICE_NUMBER'(1) << tgt) : '0;
        default: begin
          pend_d = SLICE_NUMBER'(1) << start_ptr;
          ptr_d  = start_ptr;
          if (cnt_q == thr_m1) begin
            cnt_d  = '0;
            ptr_d  = adv_ptr;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      endcase
    end
    // Parked and drained: forget the burst position.
    if (!module_enable_i && (pend_d == '0)) begin
      ptr_d  = '0;
      cnt_d  = '0;
      mode_d = DIST_SEQ;
    end
  end

  // State registers; reset discards any registered beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      pend_q <= '0;
      en_q   <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      mode_q <= DIST_SEQ;
      done_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
      en_q   <= en_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
      run_q  <= 1'b1;
    end
  end

  assign evt_out_valid_o = pend_q;
  assign evt_out_data_o  = data_q;
  assign busy_o          = (|pend_q) | (|cnt_q);
  assign burst_done_o    = done_q;

endmodule

// File: tb/tb_evt_data_distributor.sv
// Directed bench: stimulus pushes expected beats into per-slice queues; a
// monitor pops and compares on every slice handshake.
module tb_evt_data_distributor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        module_enable;
  logic [7:0]  enable;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        evt_in_valid;
  logic        evt_in_ready;
  logic [31:0] evt_in_data;
  logic [7:0]  evt_out_valid;
  logic [7:0]  evt_out_ready;
  logic [31:0] evt_out_data;
  logic        busy;
  logic        burst_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [8][$];
  logic [31:0] mon_exp;

  evt_data_distributor dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .module_enable_i (module_enable),
    .enable_i        (enable),
    .mode_i          (mode),
    .threshold_i     (threshold),
    .evt_in_valid_i  (evt_in_valid),
    .evt_in_ready_o  (evt_in_ready),
    .evt_in_data_i   (evt_in_data),
    .evt_out_valid_o (evt_out_valid),
    .evt_out_ready_i (evt_out_ready),
    .evt_out_data_o  (evt_out_data),
    .busy_o          (busy),
    .burst_done_o    (burst_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: sample one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (burst_done) done_cnt++;
      for (int s = 0; s < 8; s++) begin
        if (evt_out_valid[s] && evt_out_ready[s]) begin
          checks++;
          if (exp_q[s].size() == 0) begin
            errors++;
            $display("FAIL slice%0d_unexpected: got %h, required no beat", s, evt_out_data);
          end else begin
            mon_exp = exp_q[s].pop_front();
            if (evt_out_data !== mon_exp) begin
              errors++;
              $display("FAIL slice%0d_data: got %h, required %h", s, evt_out_data, mon_exp);
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] d, output int acc_cyc);
    bit acc = 1'b0;
    int n = 0;
    acc_cyc = -1;
    evt_in_valid = 1'b1;
    evt_in_data  = d;
    while (!acc) begin
      #4;
      acc = evt_in_ready;
      if (acc) acc_cyc = cyc;
      @(negedge clk);
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept for %h, required accept", d);
        break;
      end
    end
    evt_in_valid = 1'b0;
  endtask

  task automatic send_to(input logic [31:0] d, input int slice);
    int c;
    if (slice >= 0) exp_q[slice].push_back(d);
    send(d, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : main
    int c0, c1, d0;
    int seq2 [8] = '{0, 0, 2, 2, 7, 7, 0, 0};
    module_enable = 1'b1;
    enable        = 8'hFF;
    mode          = 2'd0;
    threshold     = 8'd4;
    evt_in_valid  = 1'b0;
    evt_in_data   = '0;
    evt_out_ready = 8'hFF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", 32'(evt_out_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(burst_done), 32'h0);
    check("reset_in_ready", 32'(evt_in_ready), 32'h0);
    check("reset_data", evt_out_data, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // SEQ threshold 4, all enabled: 4 beats each to slices 0,1,2.
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      exp_q[i / 4].push_back(32'h100 + 32'(i));
      send(32'h100 + 32'(i), c1);
      if (i == 0) c0 = c1;
    end
    check("seq4_throughput", 32'(c1 - c0), 32'd11);
    idle(3);
    check("seq4_done_pulses", 32'(done_cnt - d0), 32'd3);
    check("seq4_busy_idle", 32'(busy), 32'h0);

    // Park briefly to return ptr to 0.
    module_enable = 1'b0;
    idle(2);
    module_enable = 1'b1;

    // SEQ threshold 2, sparse mask with wrap.
    enable    = 8'b1000_0101;
    threshold = 8'd2;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) send_to(32'h200 + 32'(i), seq2[i]);
    idle(3);
    check("seq2_done_pulses", 32'(done_cnt - d0), 32'd4);

    // BCAST with slice 2 back-pressured for 5 cycles.
    mode   = 2'd1;
    enable = 8'h0F;
    for (int s = 0; s < 4; s++) exp_q[s].push_back(32'h300);
    for (int s = 0; s < 4; s++) exp_q[s].push_back(32'h301);
    evt_out_ready = 8'hFB;
    fork
      begin
        repeat (5) @(negedge clk);
        evt_out_ready = 8'hFF;
      end
    join_none
    send(32'h300, c0);
    send(32'h301, c1);
    check("bcast_stall_cycles", 32'(c1 - c0), 32'd5);
    idle(3);

    // TARGET: slice 5 disabled, so its beat is consumed silently.
    mode = 2'd2;
    send_to(32'h403, 3);
    send_to(32'h405, -1);
    #1 check("target_drop_valid", 32'(evt_out_valid), 32'h0);
    @(negedge clk);
    send_to(32'h413, 3);
    idle(3);

    // Mid-burst mode/mask change leaves the running burst on slice 2.
    mode      = 2'd0;
    enable    = 8'hFF;
    threshold = 8'd4;
    d0 = done_cnt;
    send_to(32'h505, 2);
    send_to(32'h515, 2);
    mode   = 2'd2;
    enable = 8'h30;
    send_to(32'h525, 2);
    send_to(32'h535, 2);
    send_to(32'h544, 4);
    idle(3);
    check("midburst_done", 32'(done_cnt - d0), 32'd1);

    // Disable with a beat held pending on slice 3.
    mode          = 2'd0;
    enable        = 8'hFF;
    evt_out_ready = 8'hF7;
    send_to(32'h600, 3);
    module_enable = 1'b0;
    #1;
    check("disable_busy", 32'(busy), 32'h1);
    check("disable_in_ready", 32'(evt_in_ready), 32'h0);
    check("disable_pending", 32'(evt_out_valid), 32'h08);
    @(negedge clk);
    evt_out_ready = 8'hFF;
    idle(2);
    check("disable_busy_fall", 32'(busy), 32'h0);
    module_enable = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) send_to(32'h610 + 32'(i), 0);
    idle(3);
    check("reenable_done", 32'(done_cnt - d0), 32'd1);

    // threshold 0 behaves as 1: each beat moves to the next slice.
    threshold = 8'd0;
    d0 = done_cnt;
    send_to(32'h700, 1);
    send_to(32'h701, 2);
    send_to(32'h702, 3);
    idle(3);
    check("thr0_done", 32'(done_cnt - d0), 32'd3);

    // Async reset discards a pending beat.
    evt_out_ready = 8'h00;
    send_to(32'h800, -1);
    #2 check("prereset_valid", 32'(evt_out_valid), 32'h10);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(evt_out_valid), 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_out_ready = 8'hFF;
    idle(5);
    check("postreset_valid", 32'(evt_out_valid), 32'h0);

    for (int s = 0; s < 8; s++) check($sformatf("slice%0d_leftover", s), 32'(exp_q[s].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
